// File: rtl/l1a_buf_pkg.sv
// Shared defaults for the L1A address buffer: ring, FIFO and counter widths.
package l1a_buf_pkg;

    localparam int DEF_RING_AW    = 12;
    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_CNT_W      = 24;
    localparam int DEF_ENTRY_W    = DEF_CNT_W + DEF_RING_AW;

    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_SAT = 8'hFF;

endpackage

// File: rtl/l1a_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered head, flags and count.
module l1a_fifo_fwft #(
    parameter int W  = 36,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr, r_cnt;
    logic [W-1:0]  r_dout;
    logic          r_empty, r_full;

    logic          w_pop, w_push, w_empty_nxt, w_full_nxt;
    logic [AW:0]   w_wptr_nxt, w_rptr_nxt;
    logic [W-1:0]  w_head;

    assign w_pop      = i_pop & ~r_empty;
    assign w_push     = i_push & (~r_full | w_pop);
    assign w_wptr_nxt = w_push ? r_wptr + 1'b1 : r_wptr;
    assign w_rptr_nxt = w_pop  ? r_rptr + 1'b1 : r_rptr;
    assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
    assign w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                         (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

    // The new head may be the word being written this very cycle; bypass it.
    assign w_head = (w_push && (w_rptr_nxt[AW-1:0] == r_wptr[AW-1:0])) ?
                    i_din : r_mem[w_rptr_nxt[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (w_push && !i_clr)
            r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_cnt   <= w_wptr_nxt - w_rptr_nxt;
            r_empty <= w_empty_nxt;
            r_full  <= w_full_nxt;
            if (!w_empty_nxt)
                r_dout <= w_head;
        end
    end

    assign o_dout  = r_dout;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_cnt;

endmodule

// File: rtl/l1a_addr_buf.sv
// Queues matched L1A triggers as {L1A number, ring start address} for the transfer FSM.
module l1a_addr_buf
    import l1a_buf_pkg::*;
#(
    parameter int RING_AW    = DEF_RING_AW,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RESYNC,
    input  logic                  L1A,
    input  logic                  L1A_MATCH,
    input  logic [RING_AW-1:0]    RING_WADDR,
    input  logic [RING_AW-1:0]    LATENCY,
    input  logic                  NXT_L1A,
    output logic                  L1A_BUF_MT,
    output logic                  L1A_BUF_FULL,
    output logic [RING_AW-1:0]    RD_ADDR,
    output logic [CNT_W-1:0]      EVT_NUM,
    output logic [CNT_W-1:0]      L1A_CNT,
    output logic [DEPTH_LOG2:0]   WORDS,
    output logic                  OVF,
    output logic [DROP_W-1:0]     DROP_CNT
);

    localparam int ENTRY_W = CNT_W + RING_AW;

    logic [CNT_W-1:0]    r_l1a_cnt;
    logic                r_ovf;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_match, w_push, w_drop;
    logic [RING_AW-1:0]  w_start;
    logic [ENTRY_W-1:0]  w_din, w_dout;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_match = L1A & L1A_MATCH;
    assign w_push  = w_match & (~L1A_BUF_FULL | NXT_L1A);
    assign w_drop  = w_match & L1A_BUF_FULL & ~NXT_L1A;
    assign w_start = RING_WADDR - LATENCY;
    assign w_din   = {r_l1a_cnt, w_start};

    l1a_fifo_fwft #(
        .W  (ENTRY_W),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (RESYNC),
        .i_push  (w_push),
        .i_pop   (NXT_L1A),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_empty (L1A_BUF_MT),
        .o_full  (L1A_BUF_FULL),
        .o_count (WORDS)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_l1a_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (RESYNC) begin
            r_l1a_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (L1A)
                r_l1a_cnt <= r_l1a_cnt + 1'b1;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != DROP_SAT)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign RD_ADDR  = w_dout[RING_AW-1:0];
    assign EVT_NUM  = w_dout[ENTRY_W-1:RING_AW];
    assign L1A_CNT  = r_l1a_cnt;
    assign OVF      = r_ovf;
    assign DROP_CNT = r_drop_cnt;

endmodule

// File: tb/tb_l1a_addr_buf.sv
// Scoreboard bench for l1a_addr_buf: queue model of FIFO contents, counters and flags.
module tb_l1a_addr_buf;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RESYNC = 1'b0;
    logic        L1A = 1'b0;
    logic        L1A_MATCH = 1'b0;
    logic        NXT_L1A = 1'b0;
    logic [11:0] RING_WADDR = '0;
    logic [11:0] LATENCY = '0;

    logic        L1A_BUF_MT, L1A_BUF_FULL, OVF;
    logic [11:0] RD_ADDR;
    logic [23:0] EVT_NUM, L1A_CNT;
    logic [4:0]  WORDS;
    logic [7:0]  DROP_CNT;

    l1a_addr_buf dut (
        .CLK          (CLK),
        .RST          (RST),
        .RESYNC       (RESYNC),
        .L1A          (L1A),
        .L1A_MATCH    (L1A_MATCH),
        .RING_WADDR   (RING_WADDR),
        .LATENCY      (LATENCY),
        .NXT_L1A      (NXT_L1A),
        .L1A_BUF_MT   (L1A_BUF_MT),
        .L1A_BUF_FULL (L1A_BUF_FULL),
        .RD_ADDR      (RD_ADDR),
        .EVT_NUM      (EVT_NUM),
        .L1A_CNT      (L1A_CNT),
        .WORDS        (WORDS),
        .OVF          (OVF),
        .DROP_CNT     (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] evt;
        logic [11:0] addr;
    } ent_t;

    ent_t        q[$];
    logic [23:0] m_cnt = '0;
    logic        m_ovf = 1'b0;
    logic [7:0]  m_drop = '0;
    logic [11:0] m_last_addr = '0;
    logic [23:0] m_last_evt = '0;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
        m_drop = '0;
        m_last_addr = '0;
        m_last_evt = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/mt"},    32'(L1A_BUF_MT),   32'(q.size() == 0));
        chk({tag, "/full"},  32'(L1A_BUF_FULL), 32'(q.size() == 16));
        chk({tag, "/words"}, 32'(WORDS),        32'(q.size()));
        chk({tag, "/cnt"},   32'(L1A_CNT),      32'(m_cnt));
        chk({tag, "/ovf"},   32'(OVF),          32'(m_ovf));
        chk({tag, "/drop"},  32'(DROP_CNT),     32'(m_drop));
        if (q.size() > 0) begin
            m_last_addr = q[0].addr;
            m_last_evt  = q[0].evt;
        end
        chk({tag, "/addr"}, 32'(RD_ADDR), 32'(m_last_addr));
        chk({tag, "/evt"},  32'(EVT_NUM), 32'(m_last_evt));
    endtask

    // Called just after a negedge; drives one cycle, updates model at the edge, checks at next negedge.
    task automatic step(input logic l1a, input logic match, input logic nxt,
                        input logic rs, input logic [11:0] wa, input string tag);
        bit   full, empty, matched;
        ent_t e;
        L1A = l1a; L1A_MATCH = match; NXT_L1A = nxt; RESYNC = rs; RING_WADDR = wa;
        @(posedge CLK);
        if (rs) begin
            model_clear();
        end else begin
            full    = (q.size() == 16);
            empty   = (q.size() == 0);
            matched = l1a && match;
            if (nxt && !empty) void'(q.pop_front());
            if (matched && (!full || nxt)) begin
                e.evt  = m_cnt;
                e.addr = wa - LATENCY;
                q.push_back(e);
            end else if (matched) begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop++;
            end
            if (l1a) m_cnt++;
        end
        @(negedge CLK);
        L1A = 1'b0; L1A_MATCH = 1'b0; NXT_L1A = 1'b0; RESYNC = 1'b0;
        check_state(tag);
    endtask

    task automatic push(input logic [11:0] wa, input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, wa, tag);
    endtask

    task automatic pop(input string tag);
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, tag);
    endtask

    task automatic resync();
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, "resync");
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_state("rst");
        RST = 1'b0;

        // Single event
        LATENCY = 12'h040;
        push(12'h100, "t1");
        chk("t1_addr", 32'(RD_ADDR), 32'h0C0);
        chk("t1_evt",  32'(EVT_NUM), 32'h0);
        chk("t1_cnt",  32'(L1A_CNT), 32'h1);
        pop("t1_pop");
        chk("t1_mt", 32'(L1A_BUF_MT), 32'h1);

        // Address wrap
        LATENCY = 12'h020;
        push(12'h010, "t2");
        chk("t2_addr", 32'(RD_ADDR), 32'hFF0);
        pop("t2_pop");

        // Unmatched L1A mix
        resync();
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h200, "t3a");
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h210, "t3b");
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h220, "t3c");
        chk("t3_words", 32'(WORDS), 32'd2);
        chk("t3_cnt",   32'(L1A_CNT), 32'd3);
        chk("t3_evt0",  32'(EVT_NUM), 32'd0);
        pop("t3_pop0");
        chk("t3_evt2",  32'(EVT_NUM), 32'd2);
        pop("t3_pop1");

        // Overflow
        resync();
        LATENCY = 12'h040;
        for (int i = 0; i < 16; i++) push(12'($urandom), "t4_fill");
        chk("t4_full", 32'(L1A_BUF_FULL), 32'd1);
        push(12'h333, "t4_drop");
        chk("t4_ovf",  32'(OVF), 32'd1);
        chk("t4_dcnt", 32'(DROP_CNT), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t4_order", 32'(EVT_NUM), 32'(i));
            pop("t4_pop");
        end

        // Simultaneous push and pop at full
        resync();
        for (int i = 0; i < 16; i++) push(12'(i * 7), "t5_fill");
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h555, "t5_pp");
        chk("t5_words", 32'(WORDS), 32'd16);
        chk("t5_ovf",   32'(OVF), 32'd0);
        chk("t5_evt",   32'(EVT_NUM), 32'd1);

        // Flush with L1A in the same cycle, then pops on empty
        resync();
        for (int i = 0; i < 5; i++) push(12'(i + 1), "t6_fill");
        chk("t6_words", 32'(WORDS), 32'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h777, "t6_flush");
        chk("t6_mt",  32'(L1A_BUF_MT), 32'd1);
        chk("t6_cnt", 32'(L1A_CNT), 32'd0);
        pop("t6_pop_mt");
        chk("t6_words0", 32'(WORDS), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h123, "t6_pp_mt");
        chk("t6_words1", 32'(WORDS), 32'd1);
        pop("t6_drain");

        // Drop counter saturation
        resync();
        for (int i = 0; i < 16; i++) push(12'h400, "t7_fill");
        for (int i = 0; i < 260; i++) push(12'h401, "t7_drop");
        chk("t7_sat", 32'(DROP_CNT), 32'd255);

        // Random traffic
        resync();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) LATENCY = 12'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'b0, 12'($urandom), "rnd");
        end

        // Async reset mid-stream, no clock edge in between
        for (int i = 0; i < 3; i++) push(12'h0AB, "t8_fill");
        #2 RST = 1'b1;
        #1 model_clear();
        check_state("t8_arst");
        @(negedge CLK);
        RST = 1'b0;
        push(12'h050, "t8_after");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/l1a_addr_buf.md
Name: l1a_addr_buf

Overview:
Upstream stage of the ring-to-event-buffer transfer FSM. Captures each matched L1A trigger, computes the ring-buffer start address of that event's samples, and queues it with its L1A number in a small first-word-fall-through FIFO. The transfer FSM sees L1A_BUF_MT and RD_ADDR. It latches RD_ADDR with LD_ADDR and pops the entry with NXT_L1A.

Parameters:
RING_AW, 12, ring-buffer address width (ring depth 2^RING_AW samples)
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries)
CNT_W, 24, L1A number counter width

Ports:
CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-high
RESYNC  in  1  synchronous flush: clears FIFO, counters and sticky flags
L1A  in  1  trigger pulse, one CLK wide
L1A_MATCH  in  1  qualifies L1A; event is queued only if high in the same cycle as L1A
RING_WADDR  in  RING_AW  current ring-buffer write pointer
LATENCY  in  RING_AW  trigger latency in samples (configuration; quasi-static)
NXT_L1A  in  1  pop head entry (pulse from transfer FSM)
L1A_BUF_MT  out  1  FIFO empty
L1A_BUF_FULL  out  1  FIFO full
RD_ADDR  out  RING_AW  head entry start address
EVT_NUM  out  CNT_W  head entry L1A number
L1A_CNT  out  CNT_W  running L1A count (all L1As, matched or not)
WORDS  out  DEPTH_LOG2+1  current occupancy
OVF  out  1  sticky: matched L1A dropped because FIFO full
DROP_CNT  out  8  dropped-event counter, saturates at 255

Behaviour:
- Reset (RST or RESYNC):
  - L1A_BUF_MT=1, L1A_BUF_FULL=0, WORDS=0.
  - RD_ADDR=0, EVT_NUM=0.
  - L1A_CNT=0, OVF=0, DROP_CNT=0.
  - Read and write pointers = 0.
  - RST takes priority over everything. RESYNC takes priority over L1A and NXT_L1A in the same cycle.
- L1A counting: on every L1A, L1A_CNT <= L1A_CNT+1, wrapping modulo 2^CNT_W. The value stored with an event is the pre-increment count, so the first L1A after reset is event 0.
- Push: L1A & L1A_MATCH & !full (or full & simultaneous pop) writes {L1A_CNT, (RING_WADDR - LATENCY) mod 2^RING_AW}. Subtraction wraps; no saturation.
- Drop: L1A & L1A_MATCH & full & !NXT_L1A.
  - No write; OVF <= 1 (sticky until reset).
  - DROP_CNT increments, saturating at 255.
  - L1A_CNT still increments.
- Unmatched L1A: counter increments only; no push.
- Pop: NXT_L1A & !empty advances the read pointer. NXT_L1A when empty is ignored, with no pointer or WORDS change.
- Simultaneous push and pop: both happen and WORDS is unchanged. When empty, a pop is ignored and the push still occurs.
- Latency:
  - Push at edge k gives L1A_BUF_MT=0 and RD_ADDR/EVT_NUM valid after edge k (one cycle).
  - Pop at edge k presents the next entry, or MT=1, after edge k.
- Output registration: RD_ADDR, EVT_NUM, MT, FULL and WORDS are registered with no combinational path from inputs. RD_ADDR and EVT_NUM hold the last value when empty.
- Pointer wrap: the pointers are DEPTH_LOG2+1 bits. Empty is when the pointers are equal. Full is when the MSBs differ and the rest are equal.
- LD_ADDR from the transfer FSM is not an input. RD_ADDR is stable from the push until NXT_L1A, so the transfer FSM samples it at any time while MT=0.

Decomposition:
- Package l1a_buf_pkg:
  - RING_AW, DEPTH_LOG2 and CNT_W defaults.
  - Entry width constant (CNT_W+RING_AW).
  - DROP_CNT saturation value.
- One sub-module: l1a_fifo_fwft, a generic synchronous first-word-fall-through FIFO with parameterised width and depth, exposing empty, full and count.
- Address arithmetic, counters and drop logic stay in the top level.

Test Plan:
- Single event: RST released; RING_WADDR=0x100, LATENCY=0x40; L1A with L1A_MATCH -> next cycle MT=0, RD_ADDR=0x0C0, EVT_NUM=0, L1A_CNT=1. Then NXT_L1A -> MT=1, WORDS=0.
- Address wrap: RING_WADDR=0x010, LATENCY=0x020, matched L1A -> RD_ADDR=0xFF0.
- Unmatched L1A mix: L1A sequence with match pattern 1,0,1 -> two entries, EVT_NUM 0 then 2; L1A_CNT=3.
- Overflow: 17 matched L1As without pop -> FULL=1 after the 16th, 17th dropped, OVF=1, DROP_CNT=1. Then 16 pops return EVT_NUM 0..15 in order.
- Simultaneous push and pop at full: WORDS=16, L1A+MATCH and NXT_L1A in the same cycle -> WORDS stays 16, OVF stays 0, new head EVT_NUM=1.
- Flush: RESYNC with WORDS=5 and L1A asserted in the same cycle -> MT=1, L1A_CNT=0, OVF=0. Pop on empty then has no effect. Async RST mid-stream clears all outputs immediately without waiting for a clock edge.
